// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : loader_pkg                                                 |
// | Shared defaults, FSM state encoding and helpers for inst_loader.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package loader_pkg;

  // Instruction width of the target core (the `instruction_length macro).
  localparam int DEF_INST_DEPTH = 32;
  localparam int DEF_INST_W     = 32;

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Limit a requested word count to the size of the instruction memory.
  function automatic int unsigned clamp_words(input int unsigned req,
                                              input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : inst_loader_if                                           |
// | Host control, host byte stream and instruction-memory write port.    |
// | Rev       : 1.0                                                      |
// +----------------------------------------------------------------------+
interface inst_loader_if #(
  parameter int INST_DEPTH = loader_pkg::DEF_INST_DEPTH,
  parameter int INST_W     = loader_pkg::DEF_INST_W
);

  localparam int AW = $clog2(INST_DEPTH);
  localparam int CW = AW + 1;

  // Host control
  logic              start_i;
  logic [CW-1:0]     num_words_i;
  // Host byte stream
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  // Datapath side (inst_we_i / inst_addr_i / instruction_i of the core)
  logic              inst_we_o;
  logic [AW-1:0]     inst_addr_o;
  logic [INST_W-1:0] instruction_o;
  logic              core_hold_o;
  // Status
  logic              busy_o;
  logic              done_o;

  // Loader side
  modport slave (
    input  start_i, num_words_i, byte_valid_i, byte_data_i,
    output byte_ready_o, inst_we_o, inst_addr_o, instruction_o,
           core_hold_o, busy_o, done_o
  );

  // Host / environment side
  modport master (
    output start_i, num_words_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, inst_we_o, inst_addr_o, instruction_o,
           core_hold_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : byte_packer                                                 |
// | Packs a byte stream little-endian into INST_W-bit words.             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module byte_packer #(
  parameter int INST_W = loader_pkg::DEF_INST_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_clear,
  input  wire logic              i_byte_valid,
  input  wire logic [7:0]        i_byte_data,
  output logic      [INST_W-1:0] o_word,
  output logic                   o_word_valid
);

  localparam int NB = INST_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  logic [IW-1:0]     r_idx;
  logic [INST_W-1:0] r_word;
  logic [INST_W-1:0] w_shift;
  logic              w_last_byte;

  // New bytes enter at the top and slide down, so the first byte of a
  // word ends up in bits [7:0] once the word is complete.
  generate
    if (NB == 1) begin : g_single
      assign w_shift = i_byte_data;
    end else begin : g_multi
      assign w_shift = {i_byte_data, r_word[INST_W-1:8]};
    end
  endgenerate

  assign w_last_byte  = (r_idx == IW'(NB - 1));
  assign o_word_valid = i_byte_valid && w_last_byte;
  assign o_word       = r_word;

  // Byte index and shift register; clear discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_byte_valid) begin
      r_word <= w_shift;
      r_idx  <= w_last_byte ? '0 : r_idx + IW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : inst_loader                                                 |
// | Loads a host byte stream into the core's instruction memory and      |
// | holds the core off until the load is complete.                       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_loader #(
  parameter int INST_DEPTH = loader_pkg::DEF_INST_DEPTH,
  parameter int INST_W     = loader_pkg::DEF_INST_W
) (
  input  wire logic   clk,
  input  wire logic   rst,
  inst_loader_if.slave bus
);

  import loader_pkg::*;

  localparam int AW = $clog2(INST_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(INST_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_addr;

  logic              w_start_acc;
  logic              w_byte_acc;
  logic              w_word_valid;
  logic              w_last_word;
  logic [CW-1:0]     w_num_clamped;
  logic [INST_W-1:0] w_word;

  logic              w_byte_ready;
  logic              w_we;
  logic              w_busy;
  logic              w_hold;
  logic              w_done;

  // Requests larger than the memory are cut to the memory size.
  assign w_num_clamped = CW'(clamp_words(int'(bus.num_words_i), INST_DEPTH));
  assign w_byte_acc    = bus.byte_valid_i && w_byte_ready;
  // The address of the final word is count-1; it never steps past it.
  assign w_last_word   = ({1'b0, r_addr} == (r_count - CW'(1)));

  byte_packer #(
    .INST_W (INST_W)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_start_acc),
    .i_byte_valid (w_byte_acc),
    .i_byte_data  (bus.byte_data_i),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    w_byte_ready = 1'b0;
    w_we         = 1'b0;
    w_busy       = 1'b0;
    w_hold       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_hold = (r_state != ST_DONE);
        w_done = (r_state == ST_DONE);
        if (bus.start_i) begin
          w_start_acc = 1'b1;
          w_state_nxt = (bus.num_words_i == '0) ? ST_DONE : ST_ASSEMBLE;
        end
      end
      ST_ASSEMBLE: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_word_valid) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_we        = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = w_last_word ? ST_DONE : ST_ASSEMBLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word count and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_addr  <= '0;
    end else if (w_start_acc) begin
      r_count <= (w_num_clamped > C_DEPTH) ? C_DEPTH : w_num_clamped;
      r_addr  <= '0;
    end else if ((r_state == ST_WRITE) && !w_last_word) begin
      r_addr  <= r_addr + AW'(1);
    end
  end

  assign bus.byte_ready_o  = w_byte_ready;
  assign bus.inst_we_o     = w_we;
  assign bus.inst_addr_o   = r_addr;
  assign bus.instruction_o = w_word;
  assign bus.core_hold_o   = w_hold;
  assign bus.busy_o        = w_busy;
  assign bus.done_o        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Testbench : tb_inst_loader                                           |
// | Directed stimulus with a write scoreboard for inst_loader.           |
// | Rev       : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_inst_loader;

  localparam int DEPTH = 32;
  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inst_loader_if #(.INST_DEPTH(DEPTH), .INST_W(W)) bus();

  inst_loader #(.INST_DEPTH(DEPTH), .INST_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int n_writes = 0;
  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int addr, input logic [W-1:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  // Monitor: every write pulse is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.inst_we_o === 1'b1) begin
        n_writes++;
        chk("write_byte_ready_low", 64'(bus.byte_ready_o), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h expected none",
                   bus.inst_addr_o, bus.instruction_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 64'(bus.inst_addr_o), 64'(mon_e[AW+W-1:W]));
          chk("write_data", 64'(bus.instruction_o), 64'(mon_e[W-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load(input int n);
    bus.start_i     = 1'b1;
    bus.num_words_i = CW'(n);
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (bus.byte_ready_o !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got ready 0 for 20 cycles expected ready 1");
    end else begin
      tick();
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (bus.done_o !== 1'b1 && g < 50) begin
      tick();
      g++;
    end
    chk(name, 64'(bus.done_o), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wb;
    logic [W-1:0] d;
    bus.start_i      = 1'b0;
    bus.num_words_i  = '0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = '0;

    // Reset values while reset is held
    tick();
    tick();
    chk("rst_byte_ready", 64'(bus.byte_ready_o), 64'd0);
    chk("rst_inst_we",    64'(bus.inst_we_o), 64'd0);
    chk("rst_inst_addr",  64'(bus.inst_addr_o), 64'd0);
    chk("rst_instruction",64'(bus.instruction_o), 64'd0);
    chk("rst_core_hold",  64'(bus.core_hold_o), 64'd1);
    chk("rst_busy",       64'(bus.busy_o), 64'd0);
    chk("rst_done",       64'(bus.done_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold", 64'(bus.core_hold_o), 64'd1);

    // Two-word load, bytes back to back
    start_load(2);
    chk("t1_busy",  64'(bus.busy_o), 64'd1);
    chk("t1_ready", 64'(bus.byte_ready_o), 64'd1);
    push_exp(0, 32'h0000_0013);
    push_exp(1, 32'h0010_0093);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_done("t1_done");
    chk("t1_hold",   64'(bus.core_hold_o), 64'd0);
    chk("t1_busy0",  64'(bus.busy_o), 64'd0);
    chk("t1_writes", 64'(n_writes), 64'd2);

    // Zero-word load from IDLE goes straight to DONE
    do_reset();
    chk("t2_done_before", 64'(bus.done_o), 64'd0);
    wb = n_writes;
    start_load(0);
    chk("t2_done", 64'(bus.done_o), 64'd1);
    chk("t2_busy", 64'(bus.busy_o), 64'd0);
    chk("t2_addr", 64'(bus.inst_addr_o), 64'd0);
    tick();
    chk("t2_no_write", 64'(n_writes), 64'(wb));

    // Oversized request clamps to 32 words
    wb = n_writes;
    start_load(40);
    chk("t3_done_cleared", 64'(bus.done_o), 64'd0);
    for (int i = 0; i < 32; i++) begin
      d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      push_exp(i, d);
    end
    for (int i = 0; i < 128; i++) begin
      send_byte(8'(i));
    end
    wait_done("t3_done");
    chk("t3_writes", 64'(n_writes - wb), 64'd32);
    chk("t3_last_addr", 64'(bus.inst_addr_o), 64'd31);
    // Bytes offered in DONE are refused
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = 8'h5A;
    tick();
    chk("t3_ready_done", 64'(bus.byte_ready_o), 64'd0);
    tick();
    tick();
    bus.byte_valid_i = 1'b0;
    chk("t3_still_done", 64'(bus.done_o), 64'd1);
    chk("t3_no_extra",   64'(n_writes - wb), 64'd32);

    // Valid toggling every cycle
    start_load(1);
    push_exp(0, 32'hDEAD_BEEF);
    send_byte(8'hEF); tick();
    send_byte(8'hBE); tick();
    send_byte(8'hAD); tick();
    send_byte(8'hDE);
    wait_done("t4_done");

    // Reset mid-word discards the partial word
    start_load(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    chk("t5_async_busy",  64'(bus.busy_o), 64'd0);
    chk("t5_async_ready", 64'(bus.byte_ready_o), 64'd0);
    chk("t5_async_instr", 64'(bus.instruction_o), 64'd0);
    chk("t5_async_hold",  64'(bus.core_hold_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    start_load(1);
    push_exp(0, 32'h0403_0201);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_done("t5_done");

    // start_i during ASSEMBLE is ignored
    wb = n_writes;
    start_load(2);
    push_exp(0, 32'h4433_2211);
    push_exp(1, 32'h8877_6655);
    send_byte(8'h11);
    send_byte(8'h22);
    start_load(5);
    chk("t6_busy",  64'(bus.busy_o), 64'd1);
    chk("t6_ready", 64'(bus.byte_ready_o), 64'd1);
    chk("t6_addr",  64'(bus.inst_addr_o), 64'd0);
    send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_done("t6_done");
    chk("t6_writes", 64'(n_writes - wb), 64'd2);
    chk("t6_addr_end", 64'(bus.inst_addr_o), 64'd1);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter INST_DEPTH, 32, number of instruction-memory words in the datapath.
REQ-002 Parameter INST_W, `instruction_length (32), instruction word width, a multiple of 8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 num_words_i  input  $clog2(INST_DEPTH)+1  words to load; sampled on an accepted start_i.
REQ-007 byte_valid_i  input  1  host byte-stream valid.
REQ-008 byte_data_i  input  8  host byte-stream data.
REQ-009 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-010 inst_we_o  output  1  instruction-memory write enable toward the datapath.
REQ-011 inst_addr_o  output  $clog2(INST_DEPTH)  instruction-memory write address.
REQ-012 instruction_o  output  INST_W  assembled instruction word.
REQ-013 core_hold_o  output  1  holds datapath execution off while loading.
REQ-014 busy_o  output  1  load in progress.
REQ-015 done_o  output  1  sticky load-complete flag.

Function
REQ-016 FSM states SHALL be IDLE, ASSEMBLE, WRITE, DONE.
REQ-017 IDLE/DONE + start_i, num_words_i=0 -> DONE; addr, count cleared; no write.
REQ-018 IDLE/DONE + start_i, num_words_i>0 -> ASSEMBLE; latch count, clear addr, byte index, done_o.
REQ-019 start_i in ASSEMBLE or WRITE SHALL be ignored.
REQ-020 num_words_i greater than INST_DEPTH SHALL be clamped to INST_DEPTH.
REQ-021 byte_ready_o = 1 only in ASSEMBLE; a byte transfers when byte_valid_i && byte_ready_o.
REQ-022 Bytes SHALL assemble little-endian: k-th byte of a word (k=0..INST_W/8-1) -> bits [8k+7:8k].
REQ-023 Accepting the last byte of a word -> WRITE next cycle.
REQ-024 In WRITE, inst_we_o = 1 for exactly one cycle with stable inst_addr_o and instruction_o; byte_ready_o = 0.
REQ-025 After WRITE: addr increments; if words written == latched count -> DONE, else -> ASSEMBLE.
REQ-026 Address SHALL NOT wrap; the final write uses address count-1 (at most INST_DEPTH-1).
REQ-027 byte_valid_i low in ASSEMBLE SHALL stall with no state change (no timeout).
REQ-028 Bytes offered outside ASSEMBLE are not accepted and leave state unchanged.
REQ-029 busy_o = 1 and core_hold_o = 1 in ASSEMBLE and WRITE.
REQ-030 core_hold_o = 1 in IDLE; 0 only in DONE.
REQ-031 done_o = 1 in DONE; cleared on the cycle a new load starts.
REQ-032 inst_we_o SHALL be 0 in every state other than WRITE.
REQ-033 Latency: last byte accepted at cycle N -> inst_we_o high at N+1 -> next byte acceptable at N+2.

Reset
REQ-034 rst asserted at any time, including mid-word or during WRITE, SHALL immediately force IDLE and discard any partial word.
REQ-035 Reset values: byte_ready_o=0, inst_we_o=0, inst_addr_o=0, instruction_o=0, core_hold_o=1, busy_o=0, done_o=0.

Structure
REQ-036 The FSM state enum and INST_DEPTH/INST_W defaults SHALL reside in shared package loader_pkg.
REQ-037 Byte-to-word packing SHALL be sub-module byte_packer (byte index counter, shift register, word_valid pulse).
REQ-038 The outputs SHALL connect directly to top_datapath inst_we_i, inst_addr_i and instruction_i.

Verification
REQ-039 start_i, num_words_i=2, bytes 13,00,00,00,93,00,10,00 back-to-back -> writes 0x00000013 @0 and 0x00100093 @1, each 1 cycle; then done_o=1, core_hold_o=0.
REQ-040 num_words_i=0 -> DONE next cycle, no inst_we_o pulse, done_o=1.
REQ-041 num_words_i=40 with 128 bytes -> exactly 32 writes at addresses 0..31; no write to a wrapped address 0.
REQ-042 byte_valid_i toggled 1/0 each cycle on a 1-word load of bytes EF,BE,AD,DE -> single write of 0xDEADBEEF; byte_ready_o=0 in the WRITE cycle.
REQ-043 rst pulsed after 2 bytes of word 1, then a new 1-word load of 01,02,03,04 -> write 0x04030201 @0; no stale bytes.
REQ-044 start_i pulsed during ASSEMBLE -> ignored; latched count and address unchanged.
